// File: rtl/imem_fetch_buf.sv
// rtl/imem_fetch_buf.sv - instruction memory with registered valid/ready fetch port, skid buffer and program port
// Optional per-word even parity is enabled by defining IMEM_PARITY_EN.
module imem_fetch_buf #(
    parameter int                DEPTH_WORDS = 1024,
    parameter int                ADDR_W      = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
    parameter string             INIT_HEX    = ""
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic              flush,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_instr,
    output logic [ADDR_W-1:0] rsp_addr,
    output logic [1:0]        rsp_fault,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [31:0]       prog_wdata,
    input  logic [3:0]        prog_be
);

    localparam int                IDX_W   = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [ADDR_W-3:0] DEPTH_L = (ADDR_W-2)'(DEPTH_WORDS);
    localparam logic [31:0]       NOP     = 32'h0000_0013;

    typedef struct packed {
        logic [31:0]       instr;
        logic [ADDR_W-1:0] addr;
        logic [1:0]        fault;
    } rsp_t;

    typedef enum logic [1:0] {S_EMPTY, S_ONE, S_TWO} state_t;

    logic [31:0] mem [DEPTH_WORDS];
`ifdef IMEM_PARITY_EN
    logic        par [DEPTH_WORDS];
`endif

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        logic [ADDR_W-1:0] offset;
        offset = a - BASE_ADDR;
        return (a >= BASE_ADDR) && (offset[ADDR_W-1:2] < DEPTH_L);
    endfunction

    function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_W-1:0] a);
        logic [ADDR_W-1:0] offset;
        offset = a - BASE_ADDR;
        return offset[IDX_W+1:2];
    endfunction

    // Memory contents are initialised at load time only; reset never touches them.
    initial begin
        for (int i = 0; i < DEPTH_WORDS; i++) mem[i] = '0;
`ifdef IMEM_PARITY_EN
        for (int i = 0; i < DEPTH_WORDS; i++) par[i] = ^mem[i];
`endif
    end

    logic [IDX_W-1:0] prog_idx;
    logic [31:0]      prog_merged;

    always_comb begin
        prog_idx    = word_idx(prog_addr);
        prog_merged = mem[prog_idx];
        for (int b = 0; b < 4; b++) begin
            if (prog_be[b]) prog_merged[8*b +: 8] = prog_wdata[8*b +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (prog_we && in_range(prog_addr)) begin
            mem[prog_idx] <= prog_merged;
`ifdef IMEM_PARITY_EN
            par[prog_idx] <= ^prog_merged;
`endif
        end
    end

    rsp_t             new_rsp;
    logic [IDX_W-1:0] rd_idx;

    // Misalignment outranks range; faulting requests carry a NOP instead of memory data.
    always_comb begin
        rd_idx        = word_idx(req_addr);
        new_rsp.addr  = req_addr;
        new_rsp.instr = NOP;
        new_rsp.fault = 2'b00;
        if (req_addr[1:0] != 2'b00) begin
            new_rsp.fault = 2'b01;
        end else if (!in_range(req_addr)) begin
            new_rsp.fault = 2'b10;
        end else begin
            new_rsp.instr = mem[rd_idx];
`ifdef IMEM_PARITY_EN
            if (^{par[rd_idx], mem[rd_idx]}) begin
                new_rsp.fault = 2'b11;
                new_rsp.instr = NOP;
            end
`endif
        end
    end

    state_t state, state_nxt;
    rsp_t   out_q, skid_q;
    logic   accept;

    assign accept = req_valid && req_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_EMPTY;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_EMPTY: if (accept) state_nxt = S_ONE;
            S_ONE: begin
                if (accept && !rsp_ready)      state_nxt = S_TWO;
                else if (!accept && rsp_ready) state_nxt = S_EMPTY;
            end
            S_TWO:   if (rsp_ready) state_nxt = S_ONE;
            default: state_nxt = S_EMPTY;
        endcase
        if (flush) state_nxt = S_EMPTY;
    end

    always_comb begin
        req_ready = (state != S_TWO) && !flush;
        rsp_valid = (state != S_EMPTY);
    end

    // Output register refills from the new read or the skid; the skid only catches a stalled accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q  <= '0;
            skid_q <= '0;
        end else if (!flush) begin
            case (state)
                S_EMPTY: if (accept) out_q <= new_rsp;
                S_ONE: begin
                    if (accept && rsp_ready) out_q  <= new_rsp;
                    else if (accept)         skid_q <= new_rsp;
                end
                S_TWO:   if (rsp_ready) out_q <= skid_q;
                default: ;
            endcase
        end
    end

    assign rsp_instr = out_q.instr;
    assign rsp_addr  = out_q.addr;
    assign rsp_fault = out_q.fault;

endmodule

// File: tb/tb_imem_fetch_buf.sv
// tb/tb_imem_fetch_buf.sv - directed table-driven bench for imem_fetch_buf
module tb_imem_fetch_buf;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_addr = '0;
    logic        flush = 1'b0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_instr;
    logic [31:0] rsp_addr;
    logic [1:0]  rsp_fault;
    logic        prog_we = 1'b0;
    logic [31:0] prog_addr = '0;
    logic [31:0] prog_wdata = '0;
    logic [3:0]  prog_be = '0;

    imem_fetch_buf dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .flush(flush),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_instr(rsp_instr),
        .rsp_addr(rsp_addr), .rsp_fault(rsp_fault),
        .prog_we(prog_we), .prog_addr(prog_addr), .prog_wdata(prog_wdata), .prog_be(prog_be)
    );

    always #5 clk = ~clk;

    localparam logic [31:0] NOP = 32'h0000_0013;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic prog(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        @(negedge clk);
        prog_we = 1'b1; prog_addr = a; prog_wdata = d; prog_be = be;
        @(negedge clk);
        prog_we = 1'b0;
    endtask

    // Single isolated fetch with decode ready; checks the response one cycle later.
    task automatic fetch_chk(input string name, input logic [31:0] a,
                             input logic [31:0] exp_instr, input logic [1:0] exp_fault);
        @(negedge clk);
        chk({name, " req_ready"}, {31'b0, req_ready}, 32'd1);
        req_valid = 1'b1; req_addr = a; rsp_ready = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        chk({name, " rsp_valid"}, {31'b0, rsp_valid}, 32'd1);
        chk({name, " instr"}, rsp_instr, exp_instr);
        chk({name, " fault"}, {30'b0, rsp_fault}, {30'b0, exp_fault});
        chk({name, " addr"}, rsp_addr, a);
    endtask

    typedef struct {
        string       name;
        logic [31:0] addr;
        logic [31:0] instr;
        logic [1:0]  fault;
    } vec_t;

    vec_t vecs [10];

    initial begin
        vecs[0] = '{"w4",        32'h0000_0010, 32'h0031_00B3, 2'b00};
        vecs[1] = '{"w0",        32'h0000_0000, 32'h1000_0000, 2'b00};
        vecs[2] = '{"w7",        32'h0000_001C, 32'h1000_0007, 2'b00};
        vecs[3] = '{"w1023",     32'h0000_0FFC, 32'hDEAD_BEEF, 2'b00};
        vecs[4] = '{"mis12",     32'h0000_0012, NOP,           2'b01};
        vecs[5] = '{"mis01",     32'h0000_0001, NOP,           2'b01};
        vecs[6] = '{"oor1000",   32'h0000_1000, NOP,           2'b10};
        vecs[7] = '{"oor_top",   32'hFFFF_FFFC, NOP,           2'b10};
        vecs[8] = '{"mis_oor",   32'h0000_1002, NOP,           2'b01};
        vecs[9] = '{"w5_part",   32'h0000_0014, 32'h11BB_33DD, 2'b00};

        #12;
        chk("reset rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("reset instr", rsp_instr, 32'd0);
        chk("reset addr", rsp_addr, 32'd0);
        chk("reset fault", {30'b0, rsp_fault}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle req_ready", {31'b0, req_ready}, 32'd1);
        chk("idle rsp_valid", {31'b0, rsp_valid}, 32'd0);

        for (int i = 0; i < 8; i++) prog(32'(i * 4), 32'h1000_0000 + 32'(i), 4'hF);
        prog(32'h10, 32'h0031_00B3, 4'hF);
        prog(32'h14, 32'h1122_3344, 4'hF);
        prog(32'h14, 32'hAABB_CCDD, 4'b0101);
        prog(32'hFFC, 32'hDEAD_BEEF, 4'hF);
        prog(32'h1000, 32'h5555_5555, 4'hF);

        for (int i = 0; i < 10; i++) fetch_chk(vecs[i].name, vecs[i].addr, vecs[i].instr, vecs[i].fault);

        // Back-to-back with a stall: 0x10 and 0x14 buffered, 0x18 held off until space frees.
        @(negedge clk);
        req_valid = 1'b1; req_addr = 32'h10; rsp_ready = 1'b1;
        @(negedge clk);
        req_addr = 32'h14; rsp_ready = 1'b0;
        @(negedge clk);
        req_addr = 32'h18;
        chk("b2b two req_ready", {31'b0, req_ready}, 32'd0);
        chk("b2b two addr", rsp_addr, 32'h10);
        @(negedge clk);
        chk("b2b stable addr", rsp_addr, 32'h10);
        chk("b2b stable instr", rsp_instr, 32'h0031_00B3);
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("b2b second addr", rsp_addr, 32'h14);
        chk("b2b second instr", rsp_instr, 32'h11BB_33DD);
        chk("b2b second valid", {31'b0, rsp_valid}, 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
        chk("b2b third addr", rsp_addr, 32'h18);
        chk("b2b third instr", rsp_instr, 32'h1000_0006);
        @(negedge clk);
        chk("b2b drained", {31'b0, rsp_valid}, 32'd0);

        // Flush with two buffered responses and a concurrent request.
        req_valid = 1'b1; req_addr = 32'h10; rsp_ready = 1'b0;
        @(negedge clk);
        req_addr = 32'h14;
        @(negedge clk);
        req_addr = 32'h1C; flush = 1'b1;
        #1 chk("flush req_ready", {31'b0, req_ready}, 32'd0);
        @(negedge clk);
        flush = 1'b0; req_valid = 1'b0;
        chk("flush two rsp_valid", {31'b0, rsp_valid}, 32'd0);
        @(negedge clk);
        chk("flush two later", {31'b0, rsp_valid}, 32'd0);

        // Flush from ONE with a request that would otherwise be accepted.
        req_valid = 1'b1; req_addr = 32'h10; rsp_ready = 1'b1;
        @(negedge clk);
        req_addr = 32'h1C; flush = 1'b1;
        @(negedge clk);
        flush = 1'b0; req_valid = 1'b0;
        chk("flush one rsp_valid", {31'b0, rsp_valid}, 32'd0);
        @(negedge clk);
        chk("flush one dropped", {31'b0, rsp_valid}, 32'd0);

        // Same-cycle write and fetch: old data first, new data on refetch.
        prog_we = 1'b1; prog_addr = 32'h10; prog_wdata = 32'hFFFF_FFFF; prog_be = 4'hF;
        req_valid = 1'b1; req_addr = 32'h10; rsp_ready = 1'b1;
        @(negedge clk);
        prog_we = 1'b0; req_valid = 1'b0;
        chk("raw old", rsp_instr, 32'h0031_00B3);
        fetch_chk("raw new", 32'h10, 32'hFFFF_FFFF, 2'b00);

        // Asynchronous reset mid-operation: response lost, memory kept.
        @(negedge clk);
        req_valid = 1'b1; req_addr = 32'h1C; rsp_ready = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        chk("pre-reset valid", {31'b0, rsp_valid}, 32'd1);
        #2 rst_n = 1'b0;
        #1 chk("async reset valid", {31'b0, rsp_valid}, 32'd0);
        chk("async reset instr", rsp_instr, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        fetch_chk("post-reset mem", 32'h10, 32'hFFFF_FFFF, 2'b00);

`ifdef IMEM_PARITY_EN
        dut.mem[4] = dut.mem[4] ^ 32'h0000_0100;
        fetch_chk("parity", 32'h10, NOP, 2'b11);
`endif

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
